id_issue_queue: RTL

ID_ISSUE_QUEUE -- requirements
Module: id_issue_queue

---
 rtl/id_issue_queue.sv | 125 ++++++++++++
 1 files changed

// File: rtl/id_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : id_issue_queue
// Brief    : Decode-to-issue FIFO of decoded entries with a control-flow cap.
// Revision : 1.0
// ============================================================================
module id_issue_queue #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_CF     = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     dec_valid_i,
  input  logic [DATA_WIDTH-1:0]    dec_data_i,
  input  logic                     dec_ctrl_flow_i,
  output logic                     dec_ready_o,
  output logic                     issue_valid_o,
  output logic [DATA_WIDTH-1:0]    issue_data_o,
  output logic                     issue_ctrl_flow_o,
  input  logic                     issue_ack_i,
  output logic [$clog2(DEPTH):0]   occupancy_o,
  output logic [$clog2(DEPTH):0]   cf_count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_DEPTH  = CW'(DEPTH);
  localparam logic [CW-1:0] C_MAX_CF = CW'(MAX_CF);
  localparam logic [PW-1:0] C_PTR_ONE = PW'(1);
  localparam logic [CW-1:0] C_CNT_ONE = CW'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]      r_cf;
  logic [PW-1:0]         r_rptr;
  logic [PW-1:0]         r_wptr;
  logic [CW-1:0]         r_occ;
  logic [CW-1:0]         r_cf_cnt;

  logic                  w_ready_core;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_cf_inc;
  logic                  w_cf_dec;
  logic [PW-1:0]         w_rptr_nxt;
  logic [PW-1:0]         w_wptr_nxt;
  logic [CW-1:0]         w_occ_nxt;
  logic [CW-1:0]         w_cf_nxt;
  logic [DATA_WIDTH-1:0] w_head_data_nxt;
  logic                  w_head_cf_nxt;

  always_comb begin
    w_ready_core = !flush_i
                 && ((r_occ != C_DEPTH) || issue_ack_i)
                 && (!dec_ctrl_flow_i || (r_cf_cnt < C_MAX_CF)
                     || (issue_ack_i && issue_valid_o && issue_ctrl_flow_o));
    // Reset only gates the visible handshake; all state is already held in reset.
    dec_ready_o  = w_ready_core && !rst_i;

    w_push   = dec_valid_i && w_ready_core;
    w_pop    = issue_ack_i && issue_valid_o;
    w_cf_inc = w_push && dec_ctrl_flow_i;
    w_cf_dec = w_pop && issue_ctrl_flow_o;

    w_rptr_nxt = w_pop  ? r_rptr + C_PTR_ONE : r_rptr;
    w_wptr_nxt = w_push ? r_wptr + C_PTR_ONE : r_wptr;

    w_occ_nxt = r_occ;
    if (w_push && !w_pop)      w_occ_nxt = r_occ + C_CNT_ONE;
    else if (!w_push && w_pop) w_occ_nxt = r_occ - C_CNT_ONE;

    w_cf_nxt = r_cf_cnt;
    if (w_cf_inc && !w_cf_dec)      w_cf_nxt = r_cf_cnt + C_CNT_ONE;
    else if (!w_cf_inc && w_cf_dec) w_cf_nxt = r_cf_cnt - C_CNT_ONE;

    // The new head is the entry being written when it lands on the next read slot.
    if (w_push && (r_wptr == w_rptr_nxt)) begin
      w_head_data_nxt = dec_data_i;
      w_head_cf_nxt   = dec_ctrl_flow_i;
    end else begin
      w_head_data_nxt = r_mem[w_rptr_nxt];
      w_head_cf_nxt   = r_cf[w_rptr_nxt];
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= dec_data_i;
      r_cf[r_wptr]  <= dec_ctrl_flow_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rptr            <= '0;
      r_wptr            <= '0;
      r_occ             <= '0;
      r_cf_cnt          <= '0;
      issue_valid_o     <= 1'b0;
      issue_ctrl_flow_o <= 1'b0;
      issue_data_o      <= '0;
    end else if (flush_i) begin
      r_rptr            <= '0;
      r_wptr            <= '0;
      r_occ             <= '0;
      r_cf_cnt          <= '0;
      issue_valid_o     <= 1'b0;
      issue_ctrl_flow_o <= 1'b0;
    end else begin
      r_rptr            <= w_rptr_nxt;
      r_wptr            <= w_wptr_nxt;
      r_occ             <= w_occ_nxt;
      r_cf_cnt          <= w_cf_nxt;
      issue_valid_o     <= (w_occ_nxt != '0);
      issue_ctrl_flow_o <= (w_occ_nxt != '0) && w_head_cf_nxt;
      issue_data_o      <= w_head_data_nxt;
    end
  end

  assign occupancy_o = r_occ;
  assign cf_count_o  = r_cf_cnt;

endmodule
`default_nettype wire
